// File: rtl/riscv_noc_pkg.sv
// Shared NoC constants: default link geometry for the NoC muxes and arbiters.
package riscv_noc_pkg;

   localparam int NOC_PLEN     = 64;
   localparam int NOC_CHANNELS = 2;

endpackage

// File: rtl/riscv_noc_arb_rr.sv
// Combinational round-robin arbiter: one-hot grant searched upward from a
// one-hot priority with wrap-around, via the doubled-vector subtract trick.
module riscv_noc_arb_rr #(
   parameter int N = 2
) (
   input  logic [N-1:0] req,
   input  logic [N-1:0] prio,
   output logic [N-1:0] gnt
);

   logic [2*N-1:0] dbl_req;
   logic [2*N-1:0] dbl_gnt;

   // Subtracting prio clears the lowest set request at or above prio in the
   // doubled vector; folding both halves together handles the wrap-around.
   always_comb begin
      dbl_req = {req, req};
      dbl_gnt = dbl_req & ~(dbl_req - {{N{1'b0}}, prio});
      gnt     = dbl_gnt[N-1:0] | dbl_gnt[2*N-1:N];
   end

endmodule

// File: rtl/riscv_noc_mux_rr.sv
// Merges CHANNELS flit streams onto one NoC link with per-packet round-robin
// arbitration; the granted channel keeps the link until its last flit moves.
module riscv_noc_mux_rr
   import riscv_noc_pkg::*;
#(
   parameter int PLEN     = NOC_PLEN,
   parameter int CHANNELS = NOC_CHANNELS
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [CHANNELS-1:0][PLEN-1:0]      in_flit,
   input  logic [CHANNELS-1:0]                in_last,
   input  logic [CHANNELS-1:0]                in_valid,
   output logic [CHANNELS-1:0]                in_ready,
   output logic [PLEN-1:0]                    out_flit,
   output logic                               out_last,
   output logic                               out_valid,
   input  logic                               out_ready
);

   // Handshake: a flit moves on a cycle with valid & ready both high; the
   // upstream keeps flit/last/valid stable until it sees its in_ready.

   logic [CHANNELS-1:0] active;
   logic [CHANNELS-1:0] active_next;
   logic [CHANNELS-1:0] prio;
   logic [CHANNELS-1:0] prio_next;
   logic [CHANNELS-1:0] grant;
   logic [CHANNELS-1:0] sel;
   logic                xfer;

   riscv_noc_arb_rr #(
      .N (CHANNELS)
   ) u_arb (
      .req  (in_valid),
      .prio (prio),
      .gnt  (grant)
   );

   always_comb begin
      sel       = (active != '0) ? active : grant;
      out_valid = |(sel & in_valid);
      in_ready  = sel & {CHANNELS{out_ready}};
      xfer      = out_valid & out_ready;
   end

   // AND-OR mux over the one-hot select.
   always_comb begin
      out_flit = '0;
      out_last = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         out_flit = out_flit | (in_flit[i] & {PLEN{sel[i]}});
         out_last = out_last | (in_last[i] & sel[i]);
      end
   end

   // An offered but unaccepted grant is latched too, so the chosen channel
   // cannot change under a stalled downstream.
   always_comb begin
      active_next = active;
      prio_next   = prio;
      if (active == '0) begin
         if (grant != '0) begin
            prio_next = {grant[CHANNELS-2:0], grant[CHANNELS-1]};
            if (!(xfer && out_last)) begin
               active_next = grant;
            end
         end
      end else if (xfer && out_last) begin
         active_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= '0;
         prio   <= CHANNELS'(1);
      end else begin
         active <= active_next;
         prio   <= prio_next;
      end
   end

endmodule

// File: tb/tb_riscv_noc_mux_rr.sv
// Bench for riscv_noc_mux_rr: directed scenarios plus random per-channel
// packet traffic against a channel-index reference model and scoreboard.
module tb_riscv_noc_mux_rr;

   localparam int PLEN = 64;
   localparam int C    = 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [C-1:0][PLEN-1:0] in_flit;
   logic [C-1:0]          in_last;
   logic [C-1:0]          in_valid;
   logic [C-1:0]          in_ready;
   logic [PLEN-1:0]       out_flit;
   logic                  out_last;
   logic                  out_valid;
   logic                  out_ready;

   int errors = 0;
   int checks = 0;

   riscv_noc_mux_rr #(
      .PLEN     (PLEN),
      .CHANNELS (C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_flit   (in_flit),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_flit  (out_flit),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Reference model: owning channel index (-1 = none) and highest-priority index.
   int m_owner = -1;
   int m_prio  = 0;

   logic [C-1:0]    xfer_obs;
   logic            s_out_valid;
   logic [C-1:0]    s_in_ready;
   logic [PLEN-1:0] s_out_flit;
   logic [PLEN-1:0] out_log[$];

   logic [PLEN:0]   src_q[C][$];
   logic [PLEN:0]   exp_q[C][$];
   logic [C-1:0]    vld;
   logic [C-1:0]    waiting;
   int              wait_cnt[C];
   int              pkt_id[C];
   int              cur_ch;
   logic            gen_on;
   logic            sb_on;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_pick(input logic [C-1:0] v, input int p);
      for (int k = 0; k < C; k++) begin
         if (v[(p + k) % C]) return (p + k) % C;
      end
      return -1;
   endfunction

   task automatic scoreboard();
      int ch;
      logic [PLEN:0] e;
      if (out_valid && out_ready) begin
         ch = int'(out_flit[63:56]);
         check("sb_chan_range", 64'(ch < C), 1);
         if (ch < C) begin
            check("sb_nonempty", 64'(exp_q[ch].size() > 0), 1);
            if (exp_q[ch].size() > 0) begin
               e = exp_q[ch].pop_front();
               check("sb_flit", out_flit, e[PLEN-1:0]);
               check("sb_last", 64'(out_last), 64'(e[PLEN]));
            end
            if (cur_ch >= 0) check("sb_atomic", 64'(ch), 64'(cur_ch));
            if (out_flit[39:24] == 16'd0) begin
               check("sb_wait_bound", 64'(wait_cnt[ch] <= C - 1), 1);
               waiting[ch]  = 1'b0;
               wait_cnt[ch] = 0;
            end
            if (out_last) begin
               for (int i = 0; i < C; i++) begin
                  if (i != ch && waiting[i]) wait_cnt[i]++;
               end
            end
            cur_ch = out_last ? -1 : ch;
         end
      end
   endtask

   // One clock: compare combinational outputs mid-cycle, advance the model at
   // the edge, then compare the registered state just after it.
   task automatic cycle();
      int g;
      int s;
      logic e_valid;
      logic [C-1:0] e_ready;
      logic m_xfer;
      #4;
      g = (m_owner < 0) ? rr_pick(in_valid, m_prio) : -1;
      s = (m_owner < 0) ? g : m_owner;
      e_valid = 1'b0;
      e_ready = '0;
      if (s >= 0) begin
         e_valid = in_valid[s];
         if (out_ready) e_ready = C'(1 << s);
      end
      check("out_valid", 64'(out_valid), 64'(e_valid));
      check("in_ready", 64'(in_ready), 64'(e_ready));
      check("inv_ready_onehot0", 64'($onehot0(in_ready)), 1);
      if (e_valid) begin
         check("out_flit", out_flit, in_flit[s]);
         check("out_last", 64'(out_last), 64'(in_last[s]));
      end
      m_xfer      = e_valid && out_ready;
      xfer_obs    = in_valid & in_ready;
      s_out_valid = out_valid;
      s_in_ready  = in_ready;
      s_out_flit  = out_flit;
      if (out_valid && out_ready) out_log.push_back(out_flit);
      if (sb_on) scoreboard();
      @(posedge clk);
      if (rst) begin
         m_owner = -1;
         m_prio  = 0;
      end else if (m_owner < 0) begin
         if (g >= 0) begin
            m_prio = (g + 1) % C;
            if (!(m_xfer && in_last[g])) m_owner = g;
         end
      end else if (m_xfer && in_last[m_owner]) begin
         m_owner = -1;
      end
      #1;
      check("active", 64'(dut.active), (m_owner < 0) ? 64'd0 : 64'(1 << m_owner));
      check("prio", 64'(dut.prio), 64'(1 << m_prio));
   endtask

   task automatic run_two(input logic [63:0] b0, input logic [63:0] b1, input int n, input int max_cyc);
      int k0 = 0;
      int k1 = 0;
      int cnt = 0;
      out_log.delete();
      while ((k0 < n || k1 < n) && cnt < max_cyc) begin
         in_valid   = {1'(k1 < n), 1'(k0 < n)};
         in_flit[0] = b0 + 64'(k0);
         in_flit[1] = b1 + 64'(k1);
         in_last    = {1'(k1 == n - 1), 1'(k0 == n - 1)};
         out_ready  = 1'b1;
         cycle();
         if (xfer_obs[0]) k0++;
         if (xfer_obs[1]) k1++;
         cnt++;
      end
      check("t3_done", 64'(k0 == n && k1 == n), 1);
      in_valid = '0;
   endtask

   task automatic drive_rand();
      int len;
      for (int i = 0; i < C; i++) begin
         if (vld[i] && xfer_obs[i]) begin
            void'(src_q[i].pop_front());
            vld[i] = 1'b0;
         end
         if (src_q[i].size() == 0 && gen_on && $urandom_range(0, 3) == 0) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
               logic [PLEN:0] e;
               e = {1'(k == len - 1), 8'(i), 16'(pkt_id[i]), 16'(k), 24'($urandom)};
               src_q[i].push_back(e);
               exp_q[i].push_back(e);
            end
            pkt_id[i]++;
         end
         if (!vld[i] && src_q[i].size() > 0) begin
            vld[i] = ($urandom_range(0, 3) != 0);
            if (vld[i] && src_q[i][0][39:24] == 16'd0) waiting[i] = 1'b1;
         end
         in_valid[i] = vld[i];
         if (vld[i]) begin
            in_flit[i] = src_q[i][0][PLEN-1:0];
            in_last[i] = src_q[i][0][PLEN];
         end else begin
            in_flit[i] = {$urandom, $urandom};
            in_last[i] = 1'($urandom_range(0, 1));
         end
      end
      out_ready = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      logic [63:0] exp_seq[6];
      int drain;

      rst = 1'b1;
      in_flit = '0;
      in_last = '0;
      in_valid = '0;
      out_ready = 1'b1;
      xfer_obs = '0;
      vld = '0;
      waiting = '0;
      gen_on = 1'b0;
      sb_on = 1'b0;
      cur_ch = -1;
      for (int i = 0; i < C; i++) begin
         wait_cnt[i] = 0;
         pkt_id[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;

      // Reset state and idle outputs.
      rst = 1'b0;
      repeat (3) cycle();
      check("t1_out_valid", 64'(s_out_valid), 0);
      check("t1_in_ready", 64'(s_in_ready), 0);
      check("t1_active", 64'(dut.active), 0);
      check("t1_prio", 64'(dut.prio), 1);

      // Single-flit packet never locks, but rotates priority.
      in_flit[0] = 64'hA;
      in_last = 2'b01;
      in_valid = 2'b01;
      cycle();
      check("t2_flit", s_out_flit, 64'hA);
      check("t2_ready", 64'(s_in_ready), 2'b01);
      check("t2_prio", 64'(dut.prio), 2'b10);
      check("t2_active", 64'(dut.active), 0);
      in_valid = '0;
      cycle();

      // Two competing 3-flit packets stay atomic.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      run_two(64'h10, 64'h20, 3, 20);
      exp_seq = '{64'h10, 64'h11, 64'h12, 64'h20, 64'h21, 64'h22};
      check("t3_count", 64'(out_log.size()), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < out_log.size()) check("t3_order", out_log[i], exp_seq[i]);
      end
      cycle();

      // Stalled downstream freezes the choice of ch1.
      in_flit[0] = 64'h30;
      in_flit[1] = 64'h40;
      in_last = 2'b11;
      in_valid = 2'b10;
      out_ready = 1'b0;
      repeat (4) cycle();
      check("t4_hold", s_out_flit, 64'h40);
      in_valid = 2'b11;
      cycle();
      check("t4_hold_ch0", s_out_flit, 64'h40);
      out_ready = 1'b1;
      cycle();
      check("t4_ch1_first", 64'(xfer_obs), 2'b10);
      in_valid = 2'b01;
      cycle();
      check("t4_ch0_next", 64'(xfer_obs), 2'b01);
      in_valid = '0;
      cycle();

      // Bubble in a locked packet does not break the lock.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      in_valid = 2'b01;
      in_flit[0] = 64'h50;
      in_last = 2'b00;
      cycle();
      check("t5_first", 64'(xfer_obs), 2'b01);
      in_valid = 2'b10;
      in_flit[1] = 64'h60;
      in_last = 2'b10;
      out_ready = 1'b0;
      repeat (2) begin
         cycle();
         check("t5_bubble_valid", 64'(s_out_valid), 0);
         check("t5_bubble_ready", 64'(s_in_ready), 0);
      end
      out_ready = 1'b1;
      in_valid = 2'b11;
      in_flit[0] = 64'h51;
      cycle();
      check("t5_resume_ready", 64'(s_in_ready), 2'b01);
      check("t5_resume_flit", s_out_flit, 64'h51);
      in_flit[0] = 64'h52;
      in_last = 2'b11;
      cycle();
      check("t5_last_flit", s_out_flit, 64'h52);
      in_valid = 2'b10;
      cycle();
      check("t5_ch1_flit", s_out_flit, 64'h60);
      check("t5_ch1_ready", 64'(s_in_ready), 2'b10);
      in_valid = '0;
      cycle();

      // Reset mid-packet drops the lock.
      in_valid = 2'b10;
      in_flit[1] = 64'h70;
      in_last = 2'b00;
      cycle();
      check("t6_locked", 64'(dut.active), 2'b10);
      rst = 1'b1;
      cycle();
      check("t6_active", 64'(dut.active), 0);
      check("t6_prio", 64'(dut.prio), 1);
      rst = 1'b0;
      in_valid = 2'b11;
      in_flit[0] = 64'h80;
      in_flit[1] = 64'h71;
      in_last = 2'b11;
      cycle();
      check("t6_ch0_ready", 64'(s_in_ready), 2'b01);
      check("t6_ch0_flit", s_out_flit, 64'h80);
      in_valid = 2'b10;
      cycle();
      in_valid = '0;
      cycle();

      // Random packet traffic.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      xfer_obs = '0;
      gen_on = 1'b1;
      sb_on = 1'b1;
      cur_ch = -1;
      for (int n = 0; n < 3000; n++) begin
         drive_rand();
         cycle();
      end
      gen_on = 1'b0;
      drain = 0;
      while ((src_q[0].size() > 0 || src_q[1].size() > 0 || vld != '0) && drain < 500) begin
         drive_rand();
         cycle();
         drain++;
      end
      check("drain_done", 64'(drain < 500), 1);
      for (int i = 0; i < C; i++) begin
         check("sb_leftover", 64'(exp_q[i].size()), 0);
      end
      check("traffic_ch0", 64'(pkt_id[0] > 20), 1);
      check("traffic_ch1", 64'(pkt_id[1] > 20), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
